// File: rtl/res4b_serial.sv
// -----------------------------------------------------------------------------
// res4b_serial
//
// Bit-serial subtractor. It computes zi = (xi - yi) mod 2^WIDTH, one bit per
// clock with the LSB first, and raises a borrow-out flag. This is the
// subtracting partner of the ripple-carry adder. Use it where area matters
// more than latency.
//
// Each operation takes these steps:
//   IDLE -> SUB (WIDTH cycles) -> DONE (1 cycle) -> IDLE
// The operands are captured when init is accepted in IDLE. The results zi and
// bo (and ov when it is built in) stay stable until the next operation
// completes.
//
// Optional feature:
//   RES4B_OVF_EN  When defined, this adds the signed-overflow output ov and
//                 the registers that capture the operand MSBs.
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous, active-high reset (aborts any operation)
//   init  in   start request, sampled only in IDLE
//   xi    in   minuend, WIDTH bits
//   yi    in   subtrahend, WIDTH bits
//   zi    out  difference, registered
//   bo    out  borrow out (xi < yi unsigned), registered
//   busy  out  high from the cycle after init is accepted until DONE is left
//   ov    out  signed overflow (only with RES4B_OVF_EN)
//   done  out  one-cycle pulse; zi/bo are valid in this cycle
// -----------------------------------------------------------------------------
module res4b_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic [WIDTH-1:0] xi,
    input  logic [WIDTH-1:0] yi,
    output logic [WIDTH-1:0] zi,
    output logic             bo,
    output logic             busy,
`ifdef RES4B_OVF_EN
    output logic             ov,
`endif
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SUB  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] r_reg, r_next;
    logic             br_reg, br_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] zi_reg, zi_next;
    logic             bo_reg, bo_next;
`ifdef RES4B_OVF_EN
    logic             xm_reg, xm_next;
    logic             ym_reg, ym_next;
    logic             ov_reg, ov_next;
`endif

    // One full-subtractor bit slice acts on the LSBs of the operand shift
    // registers.
    logic             d_bit;
    logic             br_step;
    logic [WIDTH-1:0] r_shift;
    logic             last_bit;

    assign d_bit    = a_reg[0] ^ b_reg[0] ^ br_reg;
    assign br_step  = (~a_reg[0] & b_reg[0]) | (~(a_reg[0] ^ b_reg[0]) & br_reg);
    assign last_bit = (cnt_reg == CW'(WIDTH - 1));

    // The result register shifts right. The new difference bit enters at the
    // MSB, so after WIDTH shifts the LSB-first bits end up in their natural
    // positions.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi = gi + 1) begin : g_rshift
            assign r_shift[gi] = r_reg[gi + 1];
        end
    endgenerate
    assign r_shift[WIDTH-1] = d_bit;

    // Next-state and datapath logic
    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        r_next     = r_reg;
        br_next    = br_reg;
        cnt_next   = cnt_reg;
        zi_next    = zi_reg;
        bo_next    = bo_reg;
`ifdef RES4B_OVF_EN
        xm_next    = xm_reg;
        ym_next    = ym_reg;
        ov_next    = ov_reg;
`endif

        case (state_reg)
            S_IDLE: begin
                if (init) begin
                    a_next     = xi;
                    b_next     = yi;
                    br_next    = 1'b0;
                    cnt_next   = '0;
                    state_next = S_SUB;
`ifdef RES4B_OVF_EN
                    xm_next    = xi[WIDTH-1];
                    ym_next    = yi[WIDTH-1];
`endif
                end
            end

            S_SUB: begin
                a_next   = {1'b0, a_reg[WIDTH-1:1]};
                b_next   = {1'b0, b_reg[WIDTH-1:1]};
                r_next   = r_shift;
                br_next  = br_step;
                cnt_next = cnt_reg + 1'b1;
                if (last_bit) begin
                    // The outputs are loaded on the edge that enters DONE,
                    // so they are already valid while done is high. Before
                    // that edge they still hold the previous result, so no
                    // partial result is ever visible.
                    zi_next    = r_shift;
                    bo_next    = br_step;
                    state_next = S_DONE;
`ifdef RES4B_OVF_EN
                    ov_next    = (xm_reg ^ ym_reg) & (xm_reg ^ r_shift[WIDTH-1]);
`endif
                end
            end

            S_DONE: begin
                // This always returns through IDLE, so a held init restarts
                // only after one IDLE cycle.
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            r_reg     <= '0;
            br_reg    <= 1'b0;
            cnt_reg   <= '0;
            zi_reg    <= '0;
            bo_reg    <= 1'b0;
`ifdef RES4B_OVF_EN
            xm_reg    <= 1'b0;
            ym_reg    <= 1'b0;
            ov_reg    <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            r_reg     <= r_next;
            br_reg    <= br_next;
            cnt_reg   <= cnt_next;
            zi_reg    <= zi_next;
            bo_reg    <= bo_next;
`ifdef RES4B_OVF_EN
            xm_reg    <= xm_next;
            ym_reg    <= ym_next;
            ov_reg    <= ov_next;
`endif
        end
    end

    assign zi   = zi_reg;
    assign bo   = bo_reg;
    assign busy = (state_reg != S_IDLE);
    assign done = (state_reg == S_DONE);
`ifdef RES4B_OVF_EN
    assign ov   = ov_reg;
`endif

endmodule

// File: tb/tb_res4b_serial.sv
// -----------------------------------------------------------------------------
// tb_res4b_serial
//
// Scoreboard bench for res4b_serial (WIDTH = 4). Expected results are pushed
// when an operation is started and popped when done pulses.
// -----------------------------------------------------------------------------
module tb_res4b_serial;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         init;
    logic [W-1:0] xi;
    logic [W-1:0] yi;
    logic [W-1:0] zi;
    logic         bo;
    logic         busy;
    logic         done;
`ifdef RES4B_OVF_EN
    logic         ov;
`endif

    res4b_serial #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .init (init),
        .xi   (xi),
        .yi   (yi),
        .zi   (zi),
        .bo   (bo),
        .busy (busy),
`ifdef RES4B_OVF_EN
        .ov   (ov),
`endif
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] z;
        logic         b;
        logic         o;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   last_done_cyc = -1;
    bit   check_period  = 1'b0;
    int   done_seen     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        e.z = x - y;
        e.b = (x < y);
        e.o = (x[W-1] ^ y[W-1]) & (x[W-1] ^ e.z[W-1]);
        return e;
    endfunction

    // Monitor: pop and compare on every done pulse
    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            done_seen++;
            if (sb.size() == 0) begin
                check_eq("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                $display("[TB] done @%0d: zi=%0d bo=%0d (exp zi=%0d bo=%0d)", cyc, zi, bo, e.z, e.b);
                check_eq("zi", 32'(zi), 32'(e.z));
                check_eq("bo", 32'(bo), 32'(e.b));
                check_eq("busy_in_done", 32'(busy), 32'd1);
`ifdef RES4B_OVF_EN
                check_eq("ov", 32'(ov), 32'(e.o));
`endif
            end
            if (check_period && last_done_cyc >= 0)
                check_eq("done_period", 32'(cyc - last_done_cyc), 32'd6);
            last_done_cyc = cyc;
        end
    end

    // Drive one init pulse and queue the expected result
    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        xi   = x;
        yi   = y;
        init = 1'b1;
        sb.push_back(model(x, y));
        @(negedge clk);
        init = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((sb.size() != 0 || busy) && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (k >= 60) check_eq("timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int busy_cnt;
        int done_at;
        rst  = 1'b1;
        init = 1'b0;
        xi   = '0;
        yi   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_zi",   32'(zi),   32'd0);
        check_eq("rst_bo",   32'(bo),   32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
`ifdef RES4B_OVF_EN
        check_eq("rst_ov",   32'(ov),   32'd0);
`endif

        // Latency and busy length: 9 - 5
        start_op(4'd9, 4'd5);
        busy_cnt = 0;
        done_at  = 0;
        for (int k = 1; k <= 8; k++) begin
            if (busy) busy_cnt++;
            if (done && done_at == 0) done_at = k;
            @(negedge clk);
        end
        check_eq("latency", 32'(done_at), 32'd5);
        check_eq("busy_len", 32'(busy_cnt), 32'd5);
        wait_idle();

        // Directed operand patterns
        start_op(4'd5,  4'd9);  wait_idle();
        start_op(4'd0,  4'd1);  wait_idle();
        start_op(4'd15, 4'd15); wait_idle();
        start_op(4'd8,  4'd1);  wait_idle();
        start_op(4'd7,  4'd15); wait_idle();
        for (int k = 0; k < 6; k++) begin
            start_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            wait_idle();
        end

        // init and operand changes during SUB are ignored
        start_op(4'd9, 4'd5);
        xi   = 4'd2;
        yi   = 4'd7;
        init = 1'b1;
        repeat (2) @(negedge clk);
        init = 1'b0;
        wait_idle();
        check_eq("ignore_zi", 32'(zi), 32'd4);

        // Reset in the 3rd SUB cycle aborts the operation
        @(negedge clk);
        xi   = 4'd9;
        yi   = 4'd5;
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        done_seen = 0;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_zi",   32'(zi),   32'd0);
        check_eq("abort_bo",   32'(bo),   32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        repeat (8) @(negedge clk);
        check_eq("abort_no_done", 32'(done_seen), 32'd0);

        // rst and init together: rst wins
        rst  = 1'b1;
        init = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        init = 1'b0;
        check_eq("rst_over_init", 32'(busy), 32'd0);
        @(negedge clk);

        // init held for 20 cycles: accepted at edges 0, 6, 12 and 18
        xi   = 4'd3;
        yi   = 4'd1;
        init = 1'b1;
        for (int k = 0; k < 4; k++) sb.push_back(model(4'd3, 4'd1));
        check_period  = 1'b1;
        last_done_cyc = -1;
        done_seen     = 0;
        repeat (20) @(negedge clk);
        init = 1'b0;
        wait_idle();
        check_period = 1'b0;
        check_eq("held_done_count", 32'(done_seen), 32'd4);
        check_eq("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
